// File: rtl/apb_arbiter_if.sv
// Bundles the two requester ports and the APB requester-side bus of the arbiter.
// The arbiter connects through "slave"; the requesters and completer connect through "master".
interface apb_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m0_write;
    logic        m1_write;
    logic        m0_done;
    logic        m1_done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic        pready;
    logic [31:0] prdata;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_write, m1_write,
        output m0_done, m1_done, rdata, err,
        output paddr, pwdata, pwrite, psel, penable,
        input  pready, prdata
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_write, m1_write,
        input  m0_done, m1_done, rdata, err,
        input  paddr, pwdata, pwrite, psel, penable,
        output pready, prdata
    );
endinterface

// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB completer.
// One transfer at a time; a completer that stalls TIMEOUT cycles is aborted with err.
module apb_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    apb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        lastServed_q, lastServed_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        m0Done_q, m0Done_d;
    logic        m1Done_q, m1Done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            lastServed_q <= 1'b1;
            waitCnt_q    <= 8'd0;
            paddr_q      <= 32'd0;
            pwdata_q     <= 32'd0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            m0Done_q     <= 1'b0;
            m1Done_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            lastServed_q <= lastServed_d;
            waitCnt_q    <= waitCnt_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            m0Done_q     <= m0Done_d;
            m1Done_q     <= m1Done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        lastServed_d = lastServed_q;
        waitCnt_d    = waitCnt_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        m0Done_d     = 1'b0;
        m1Done_d     = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        pick         = 1'b0;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                // On a tie the requester that was not served last wins.
                if (bus.m0_req && bus.m1_req) begin
                    pick = ~lastServed_q;
                end else begin
                    pick = bus.m1_req;
                end
                if (bus.m0_req || bus.m1_req) begin
                    grant_d  = pick;
                    paddr_d  = pick ? bus.m1_addr  : bus.m0_addr;
                    pwdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
                    pwrite_d = pick ? bus.m1_write : bus.m0_write;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                waitCnt_d = 8'd0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready wins over an expiring wait count.
                if (bus.pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    m0Done_d  = ~grant_q;
                    m1Done_d  = grant_q;
                    if (!pwrite_q) begin
                        rdata_d = bus.prdata;
                    end
                    state_d = DONE;
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    m0Done_d  = ~grant_q;
                    m1Done_d  = grant_q;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            DONE: begin
                lastServed_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.m0_done = m0Done_q;
    assign bus.m1_done = m1Done_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: drivers push expected completions to a scoreboard
// queue, and a negedge monitor pops and compares each time a done pulse appears.
module tb_apb_arbiter;

    typedef struct {
        int          master;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic        err;
        logic [31:0] rdata;
        int          penCycles;
        int          gap;
    } expect_t;

    logic clk;
    logic rst;
    apb_arbiter_if bus();

    apb_arbiter #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    expect_t sbQ[$];
    int checks = 0;
    int passes = 0;
    int readyDelay = 0;
    logic [31:0] respData = 32'd0;
    logic errOutside = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Completer model: pready rises on the (readyDelay+1)-th ACCESS cycle.
    initial begin
        int accCnt;
        accCnt = 0;
        bus.pready = 1'b0;
        bus.prdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst && bus.psel && bus.penable) begin
                bus.pready = (accCnt == readyDelay);
                bus.prdata = respData;
                accCnt++;
            end else begin
                bus.pready = 1'b0;
                accCnt = 0;
            end
        end
    end

    // Monitor: tracks psel/penable lengths and grant spacing, checks each completion.
    initial begin
        int cyc, lastRise, gapSeen, pselCnt, penCnt;
        logic prevPsel, capWrite;
        logic [31:0] capAddr, capWdata;
        expect_t e;
        cyc = 0; lastRise = -1; gapSeen = 0; pselCnt = 0; penCnt = 0;
        prevPsel = 1'b0; capWrite = 1'b0; capAddr = 32'd0; capWdata = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                lastRise = -1; pselCnt = 0; penCnt = 0; prevPsel = 1'b0;
            end else begin
                if (bus.psel && !prevPsel) begin
                    gapSeen  = (lastRise >= 0) ? cyc - lastRise : 0;
                    lastRise = cyc;
                    pselCnt  = 0;
                    penCnt   = 0;
                end
                if (bus.psel) pselCnt++;
                if (bus.penable) begin
                    penCnt++;
                    capAddr  = bus.paddr;
                    capWdata = bus.pwdata;
                    capWrite = bus.pwrite;
                end
                prevPsel = bus.psel;
                if (!bus.m0_done && !bus.m1_done && bus.err) errOutside = 1'b1;
                if (bus.m0_done || bus.m1_done) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected done: got m0_done=%0b m1_done=%0b, required none", bus.m0_done, bus.m1_done);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("done mask", {30'd0, bus.m1_done, bus.m0_done}, (e.master == 1) ? 32'd2 : 32'd1);
                        checkOutput("err", {31'd0, bus.err}, {31'd0, e.err});
                        checkOutput("rdata", bus.rdata, e.rdata);
                        checkOutput("paddr", capAddr, e.addr);
                        checkOutput("pwrite", {31'd0, capWrite}, {31'd0, e.write});
                        if (e.write) checkOutput("pwdata", capWdata, e.wdata);
                        checkOutput("penable cycles", penCnt, e.penCycles);
                        checkOutput("psel cycles", pselCnt, e.penCycles + 1);
                        checkOutput("bus idle at done", {30'd0, bus.psel, bus.penable}, 32'd0);
                        if (e.gap != 0) checkOutput("grant spacing", gapSeen, e.gap);
                    end
                end
            end
        end
    end

    task automatic pushExpect(input int m, input logic [31:0] a, input logic [31:0] wd, input logic w,
                              input logic er, input logic [31:0] rd, input int pen, input int gap);
        expect_t e;
        e.master = m; e.addr = a; e.wdata = wd; e.write = w;
        e.err = er; e.rdata = rd; e.penCycles = pen; e.gap = gap;
        sbQ.push_back(e);
    endtask

    task automatic driveReq(input int m, input logic [31:0] a, input logic [31:0] wd, input logic w);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        if (m == 1) begin
            bus.m1_req = 1'b1; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_write = w;
        end else begin
            bus.m0_req = 1'b1; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_write = w;
        end
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = (m == 1) ? bus.m1_done : bus.m0_done;
        end
        if (m == 1) bus.m1_req = 1'b0;
        else        bus.m0_req = 1'b0;
        if (!seen) begin
            checks++;
            $display("[TB] FAIL done wait m%0d: got no done in %0d cycles, required a done pulse", m, n);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int m, input logic [31:0] a, input logic [31:0] wd, input logic w,
                                 input int delay, input logic [31:0] resp,
                                 input logic er, input logic [31:0] rd, input int pen);
        readyDelay = delay;
        respData   = resp;
        pushExpect(m, a, wd, w, er, rd, pen, 0);
        driveReq(m, a, wd, w);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset psel/penable", {30'd0, bus.psel, bus.penable}, 32'd0);
        checkOutput("reset rdata", bus.rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bus.m0_req = 1'b0; bus.m0_addr = 32'd0; bus.m0_wdata = 32'd0; bus.m0_write = 1'b0;
        bus.m1_req = 1'b0; bus.m1_addr = 32'd0; bus.m1_wdata = 32'd0; bus.m1_write = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reset psel", {31'd0, bus.psel}, 32'd0);
        checkOutput("reset penable", {31'd0, bus.penable}, 32'd0);
        checkOutput("reset paddr", bus.paddr, 32'd0);
        checkOutput("reset pwdata", bus.pwdata, 32'd0);
        checkOutput("reset done/err/pwrite", {28'd0, bus.m0_done, bus.m1_done, bus.err, bus.pwrite}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(0, 32'h10, 32'h12345678, 1'b1, 0, 32'hFFFF0000, 1'b0, 32'h0, 1);
        applyStimulus(1, 32'h20, 32'h0, 1'b0, 3, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4);
        applyStimulus(0, 32'h14, 32'h0F0F0F0F, 1'b1, 2, 32'h77777777, 1'b0, 32'hCAFEF00D, 3);

        // Fresh reset so requester 0 wins the first tie, then both request continuously.
        resetPulse();
        readyDelay = 0;
        respData   = 32'h5A5A0001;
        pushExpect(0, 32'h100, 32'hA0A0A0A0, 1'b1, 1'b0, 32'h0,        1, 0);
        pushExpect(1, 32'h200, 32'h0,        1'b0, 1'b0, 32'h5A5A0001, 1, 4);
        pushExpect(0, 32'h104, 32'hB0B0B0B0, 1'b1, 1'b0, 32'h5A5A0001, 1, 4);
        pushExpect(1, 32'h204, 32'h0,        1'b0, 1'b0, 32'h5A5A0001, 1, 4);
        fork
            begin
                driveReq(0, 32'h100, 32'hA0A0A0A0, 1'b1);
                driveReq(0, 32'h104, 32'hB0B0B0B0, 1'b1);
            end
            begin
                driveReq(1, 32'h200, 32'h0, 1'b0);
                driveReq(1, 32'h204, 32'h0, 1'b0);
            end
        join

        applyStimulus(0, 32'h300, 32'h0, 1'b0, 1000, 32'hDEADBEEF, 1'b1, 32'h5A5A0001, 16);
        applyStimulus(1, 32'h304, 32'h0, 1'b0, 15, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE, 16);

        // Abort a stalled read with reset: outputs drop at once and no done follows.
        readyDelay = 1000;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h30; bus.m1_write = 1'b0;
        n = 0;
        while (!bus.penable && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached ACCESS", {31'd0, bus.penable}, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid reset psel/penable", {30'd0, bus.psel, bus.penable}, 32'd0);
        checkOutput("mid reset paddr", bus.paddr, 32'd0);
        checkOutput("mid reset rdata", bus.rdata, 32'd0);
        checkOutput("mid reset done", {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
        @(negedge clk);
        bus.m1_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1, 32'h40, 32'h0, 1'b0, 0, 32'h13572468, 1'b0, 32'h13572468, 1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 32'd0);
        checkOutput("err outside done", {31'd0, errOutside}, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max ACCESS-phase cycles with pready low before abort (legal 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: m0_req / m1_req  input  1  requester 0/1 transfer request, level.
REQ-005 SHALL have ports: m0_addr / m1_addr  input  32  requester transfer address.
REQ-006 SHALL have ports: m0_wdata / m1_wdata  input  32  requester write data.
REQ-007 SHALL have ports: m0_write / m1_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports: m0_done / m1_done  output  1  one-cycle completion pulse to requester 0/1.
REQ-009 SHALL have port: rdata  output  32  read data; valid while a done pulse is high after a read.
REQ-010 SHALL have port: err  output  1  timeout flag; valid while a done pulse is high.
REQ-011 SHALL have ports: paddr, pwdata  output  32 each; pwrite, psel, penable  output  1 each  APB requester side.
REQ-012 SHALL have ports: pready  input  1; prdata  input  32  APB completer response.

Function
REQ-013 SHALL use FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE; all outputs registered.
REQ-014 In IDLE, with no m*_req high, SHALL stay in IDLE with psel=penable=0.
REQ-015 In IDLE, with one requester high, SHALL grant it; with both high, SHALL grant the requester not served last (round-robin).
REQ-016 On grant SHALL latch that requester's addr/wdata/write into paddr/pwdata/pwrite, set psel=1, penable=0, and enter SETUP.
REQ-017 Latency: req high at edge N -> psel=1 from edge N to edge N+1 (SETUP); penable=1 from edge N+1 (ACCESS).
REQ-018 SETUP SHALL last exactly one cycle, then go to ACCESS with psel=1, penable=1.
REQ-019 paddr, pwdata and pwrite SHALL be held stable from SETUP through the end of ACCESS.
REQ-020 In ACCESS, pready=1 SHALL end the transfer: psel=penable=0, go to DONE, granted done=1, err=0.
REQ-021 A read completion SHALL capture prdata into rdata; a write completion SHALL leave rdata unchanged.
REQ-022 In ACCESS, SHALL count consecutive pready=0 cycles; on the TIMEOUT-th such cycle SHALL go to DONE with psel=penable=0, err=1 and rdata unchanged.
REQ-023 pready=1 in the same cycle the count reaches TIMEOUT SHALL take priority, giving normal completion with err=0.
REQ-024 The wait counter SHALL clear on entry to ACCESS; its width SHALL be 8 bits.
REQ-025 DONE SHALL last exactly one cycle; only the granted done SHALL be high, and the other done SHALL stay 0.
REQ-026 DONE SHALL update the last-served pointer to the granted requester and then return to IDLE.
REQ-027 err SHALL be 0 whenever no done is high; rdata SHALL hold its value between completions.
REQ-028 Requesters SHALL hold req and payload stable until their done; each drops req in its done cycle.
REQ-029 A request seen in IDLE right after DONE SHALL be arbitrated normally; minimum transfer period is 4 cycles.
REQ-030 m*_req changes outside IDLE SHALL be ignored; the grant is never revoked mid-transfer.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE; psel, penable, pwrite, m0_done, m1_done, err = 0; paddr, pwdata, rdata = 0; wait counter 0; last-served = requester 1, so requester 0 wins the first tie.
REQ-032 rst asserted mid-transfer SHALL abort it with no done pulse; after release the bus is idle and requests restart from IDLE.

Verification
REQ-033 Single write: m0_req=1, addr=0x10, wdata=0x12345678, write=1, pready=1 -> psel 2 cycles, penable 1 cycle, paddr=0x10, pwdata=0x12345678, m0_done 1 cycle, err=0.
REQ-034 Read with wait states: m1 read addr=0x20, pready low for 3 ACCESS cycles then high with prdata=0xCAFEF00D -> penable 4 cycles, m1_done pulses, rdata=0xCAFEF00D.
REQ-035 Contention: m0 and m1 both requesting continuously after reset -> grants alternate m0, m1, m0, m1, each transfer 4 cycles apart.
REQ-036 Timeout: TIMEOUT=16, pready held 0 -> after 16 ACCESS cycles psel=penable=0, done=1, err=1, rdata unchanged.
REQ-037 Timeout tie: pready=1 on the 16th ACCESS cycle -> err=0 and, for a read, rdata=prdata.
REQ-038 Reset in ACCESS: rst pulse during a read -> all outputs 0 at once, no done; the next m1-only request completes normally.
